// File: rtl/seq_mul_32_if.sv
// rtl/seq_mul_32_if.sv - start/busy/done handshake bundle for the sequential multiplier
//
// Signals:
//   start   request toward the multiplier, accepted only while busy=0
//   clr     synchronous abort back to idle
//   a, b    32-bit multiplicand / multiplier, sampled on accept
//   busy    multiplier is in RUN or DONE
//   done    one-cycle pulse, product valid
//   product 64-bit result, held until the next accept
//   hi_nz   product[63:32] != 0
// Modports: master = ALU issue logic, slave = multiplier.

interface seq_mul_32_if;
    logic        start;
    logic        clr;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        hi_nz;

    modport master (
        output start, clr, a, b,
        input  busy, done, product, hi_nz
    );

    modport slave (
        input  start, clr, a, b,
        output busy, done, product, hi_nz
    );
endinterface

// File: rtl/seq_mul_32.sv
// rtl/seq_mul_32.sv - multi-cycle unsigned 32x32->64 shift-add multiplier
//
// Modules:
//   rca_32     32-bit ripple-carry adder/subtractor
//              ports: a, b, sub in; s, c32 (carry out), of (signed overflow) out
//   seq_mul_32 shift-add multiplier controller, one rca_32 step per cycle
//              ports: clk, rst_n (async active-low), bus (seq_mul_32_if.slave)
//              parameter EARLY_EXIT: stop once all remaining multiplier bits are zero

module rca_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] s,
    output logic        c32,
    output logic        of
);
    logic [32:0] c;
    logic [31:0] bx;

    always_comb begin
        bx   = b ^ {32{sub}};
        c    = '0;
        c[0] = sub;
        s    = '0;
        for (int i = 0; i < 32; i++) begin
            s[i]     = a[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    assign c32 = c[32];
    assign of  = c[32] ^ c[31];
endmodule

module seq_mul_32 #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_mul_32_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] m_reg;
    logic [31:0] a_reg;
    logic [31:0] q_reg;
    logic [5:0]  cnt;
    logic [63:0] product_reg;
    logic        hi_nz_reg;

    logic [31:0] addend;
    logic [31:0] sum;
    logic        c32;
    logic        unused_of;
    logic [63:0] acc_next;
    logic        last_iter;
    logic        rest_zero;
    logic [63:0] result;

    assign addend = q_reg[0] ? m_reg : 32'd0;

    rca_32 u_add (
        .a   (a_reg),
        .b   (addend),
        .sub (1'b0),
        .s   (sum),
        .c32 (c32),
        .of  (unused_of)
    );

    // 65-bit right shift of {c32, sum, Q}: the carry lands in A[31] so it is never lost.
    assign acc_next  = {c32, sum, q_reg[31:1]};
    assign last_iter = (cnt == 6'd31);

    // After this step the multiplier bits still to be processed are acc_next[30-cnt:0].
    assign rest_zero = (acc_next[31:0] & (32'hFFFF_FFFF >> (cnt + 6'd1))) == 32'd0;

    // With fewer than 32 steps the partial product still sits high in {A,Q};
    // realign it. On the 32nd step the shift is zero, so one expression covers both modes.
    assign result = acc_next >> (6'd31 - cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            m_reg       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            product_reg <= '0;
            hi_nz_reg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.clr) begin
                        m_reg <= bus.a;
                        q_reg <= bus.b;
                        a_reg <= '0;
                        cnt   <= '0;
                        if (EARLY_EXIT && (bus.b == 32'd0)) begin
                            state       <= ST_DONE;
                            product_reg <= '0;
                            hi_nz_reg   <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.clr) begin
                        state <= ST_IDLE;
                    end else begin
                        a_reg <= acc_next[63:32];
                        q_reg <= acc_next[31:0];
                        cnt   <= cnt + 6'd1;
                        if (last_iter || (EARLY_EXIT && rest_zero)) begin
                            state       <= ST_DONE;
                            product_reg <= result;
                            hi_nz_reg   <= |result[63:32];
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_DONE);
    assign bus.product = product_reg;
    assign bus.hi_nz   = hi_nz_reg;
endmodule

// File: doc/seq_mul_32.md
Name: seq_mul_32

Overview:
- Multi-cycle unsigned 32x32->64 shift-add multiplier controller.
- Owns one instance of the existing rca_32 adder, tied with sub=0, and sequences it once per cycle to accumulate partial products.
- Sits beside the combinational ALU as the MUL unit, with a start/busy/done handshake toward the ALU issue logic.

Parameters:
- EARLY_EXIT, 0: when 1, stop iterating once all unprocessed multiplier bits are zero and finish with an alignment shift.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only while busy=0
- clr  input  1  synchronous abort to IDLE
- a  input  32  multiplicand, sampled on accept
- b  input  32  multiplier, sampled on accept
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; product valid
- product  output  64  result, held until the next accept
- hi_nz  output  1  product[63:32] != 0, valid with product

Behaviour:
- Registers:
  - M (32b) holds the multiplicand.
  - A (32b) is the accumulator high half.
  - Q (32b) holds the multiplier and low product bits.
  - cnt (6b) counts iterations.
- States: IDLE, RUN, DONE.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, product=0, hi_nz=0; A, Q, M, cnt = 0.
- IDLE:
  - start=1 at an edge loads M<=a, Q<=b, A<=0, cnt<=0, then goes to RUN.
  - Exception: EARLY_EXIT=1 and b==0 goes to DONE directly with result 0.
- RUN, each cycle:
  - rca_32 computes {c32,s} = A + (Q[0] ? M : 0).
  - Update {A,Q} <= {c32, s, Q[31:1]}, i.e. a 65-bit right shift; c32 is never dropped. cnt <= cnt+1.
  - The rca_32 of output is ignored.
- RUN exit, EARLY_EXIT=0:
  - After exactly 32 RUN cycles (cnt==31 at the edge), go to DONE.
  - Captured result is {A,Q} as updated on that edge.
- RUN exit, EARLY_EXIT=1:
  - Exit at the end of the RUN cycle in which the updated unprocessed bits Q[31-(cnt+1):0] are all zero, or at cnt==31, whichever comes first.
  - Captured result is ({A,Q} >> (31-cnt)), using the updated {A,Q} and the pre-increment cnt.
  - RUN cycle count = index of the highest set bit of b, plus 1.
- DONE:
  - Lasts exactly one cycle: done=1, product and hi_nz updated on DONE entry.
  - Next state is IDLE unconditionally.
- Latency:
  - EARLY_EXIT=0: accept edge at cycle 0, done=1 during cycle 33.
  - EARLY_EXIT=1: done during cycle k+1 for k RUN cycles; b==0 gives done in cycle 1.
- busy rises the cycle after accept and falls the cycle after DONE.
  - busy=1 while done=1, so start cannot be accepted during DONE.
- start while busy=1 is ignored; it is not queued and has no effect.
- Back-to-back: start held high in the first IDLE cycle after DONE is accepted; throughput is one op per 34 cycles (EARLY_EXIT=0).
- clr=1:
  - In RUN or DONE, go to IDLE next edge; done is not asserted; product and hi_nz keep their previous value.
  - clr has priority over start in the same cycle.
  - In IDLE, clr=1 with start=1 does not accept.
- a and b may change freely after accept; only the sampled values are used.
- Reset mid-RUN: outputs return to reset values immediately (asynchronous); the partial result is lost.
- All arithmetic is unsigned; signed callers pre-negate.

Test Plan:
- EARLY_EXIT=0, a=3, b=5, start one cycle -> busy=1 from cycle 1; done=1 only in cycle 33; product=64'h0000_0000_0000_000F; hi_nz=0.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001, hi_nz=1; the carry path via c32 is exercised.
- Start at cycle 0 with a=2, b=7; pulse start at cycle 10 with a=9, b=9 -> the second request is ignored; product=14 at cycle 33; next accept possible at cycle 34.
- Assert clr at cycle 12 of an op; and, in a separate run, drive rst_n=0 mid-RUN -> clr case: IDLE next cycle, no done, product unchanged from the prior op; reset case: all outputs 0 immediately, and a new op afterwards completes correctly.
- EARLY_EXIT=1, b=1, a=32'h1234_5678 -> 1 RUN cycle, done in cycle 2, product=32'h1234_5678 zero-extended. b=0 -> done in cycle 1, product=0. b=32'h8000_0000, a=2 -> 32 RUN cycles, product=64'h1_0000_0000.
- 500 random (a,b) pairs, both EARLY_EXIT values -> product equals a*b computed in 64-bit; done width is always 1 cycle; latency matches the formula.
